// File: rtl/route_playback.sv
// Replays a recorded route from the route RAM to the servo driver.
// Each RAM word {dir, count} holds dir on MoveDir for count ticks of TICK_DIV cycles.
module route_playback #(
  parameter int                   ADDR_WIDTH  = 10,
  parameter int                   COUNT_WIDTH = 14,
  parameter int                   DIR_WIDTH   = 3,
  parameter int                   TICK_DIV    = 500000,
  parameter logic [DIR_WIDTH-1:0] STOP_DIR    = '0
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic                             i_stop,
  input  logic                             i_pause,
  input  logic [ADDR_WIDTH-1:0]            i_last_address,
  output logic [ADDR_WIDTH-1:0]            o_mem_address,
  input  logic [DIR_WIDTH+COUNT_WIDTH-1:0] i_mem_read_data,
  output logic [DIR_WIDTH-1:0]             o_move_dir,
  output logic [COUNT_WIDTH-1:0]           o_remaining,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [2:0]                       o_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DIR_WIDTH-1:0]   r_dir;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [PW-1:0]          r_presc;

  state_t                 w_state_next;
  logic [ADDR_WIDTH-1:0]  w_addr_next;
  logic [DIR_WIDTH-1:0]   w_dir_next;
  logic [COUNT_WIDTH-1:0] w_rem_next;
  logic [PW-1:0]          w_presc_next;

  logic [COUNT_WIDTH-1:0] w_count;
  logic [DIR_WIDTH-1:0]   w_dir;
  logic                   w_tick;

  assign w_count = i_mem_read_data[COUNT_WIDTH-1:0];
  assign w_dir   = i_mem_read_data[DIR_WIDTH+COUNT_WIDTH-1:COUNT_WIDTH];
  assign w_tick  = (r_presc == TICK_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_dir       <= STOP_DIR;
      r_remaining <= '0;
      r_presc     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_dir       <= w_dir_next;
      r_remaining <= w_rem_next;
      r_presc     <= w_presc_next;
    end
  end

  // Priority: Stop > Pause > Start > normal progress. Pause only acts in FETCH/LATCH/RUN.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_dir_next   = r_dir;
    w_rem_next   = r_remaining;
    w_presc_next = r_presc;
    if (i_stop) begin
      w_state_next = S_IDLE;
      w_addr_next  = '0;
      w_dir_next   = STOP_DIR;
      w_rem_next   = '0;
      w_presc_next = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            w_state_next = S_FETCH;
            w_addr_next  = '0;
            w_dir_next   = STOP_DIR;
            w_presc_next = '0;
          end
        end
        S_FETCH: begin
          if (!i_pause) w_state_next = S_LATCH;
        end
        S_LATCH: begin
          if (!i_pause) begin
            if (w_count == '0) begin
              w_state_next = S_DONE;
              w_dir_next   = STOP_DIR;
            end else begin
              w_state_next = S_RUN;
              w_dir_next   = w_dir;
              w_rem_next   = w_count;
              w_presc_next = '0;
            end
          end
        end
        S_RUN: begin
          if (!i_pause) begin
            if (w_tick) begin
              w_presc_next = '0;
              w_rem_next   = r_remaining - COUNT_WIDTH'(1);
              // The last tick of an entry either ends the route or fetches the next word.
              if (r_remaining == COUNT_WIDTH'(1)) begin
                if (r_addr == i_last_address) begin
                  w_state_next = S_DONE;
                  w_dir_next   = STOP_DIR;
                end else begin
                  w_state_next = S_FETCH;
                  w_addr_next  = r_addr + ADDR_WIDTH'(1);
                end
              end
            end else begin
              w_presc_next = r_presc + PW'(1);
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_dir_next   = STOP_DIR;
        end
      endcase
    end
  end

  // r_dir carries the previous entry's dir through FETCH/LATCH and is STOP_DIR in IDLE/DONE.
  assign o_move_dir    = (r_state == S_RUN && i_pause) ? STOP_DIR : r_dir;
  assign o_mem_address = r_addr;
  assign o_remaining   = r_remaining;
  assign o_busy        = (r_state == S_FETCH) || (r_state == S_LATCH) || (r_state == S_RUN);
  assign o_done        = (r_state == S_DONE);
  assign o_state       = r_state;

endmodule

// File: tb/tb_route_playback.sv
// Directed bench for route_playback with TICK_DIV=4 and a 1-cycle-latency RAM model.
module tb_route_playback;

  localparam int AW = 10;
  localparam int CW = 14;
  localparam int DW = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic             clk;
  logic             i_reset, i_start, i_stop, i_pause;
  logic [AW-1:0]    i_last_address;
  logic [AW-1:0]    o_mem_address;
  logic [DW+CW-1:0] rdata;
  logic [DW-1:0]    o_move_dir;
  logic [CW-1:0]    o_remaining;
  logic             o_busy, o_done;
  logic [2:0]       o_state;

  logic [DW+CW-1:0] mem [0:1023];

  int n_checks = 0;
  int n_err    = 0;
  int run_cyc  = 0;
  int run_cnt [0:7];
  logic [2:0] last_state = ST_IDLE;
  logic [DW-1:0] exp_q[$];

  route_playback #(
    .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .DIR_WIDTH(DW), .TICK_DIV(4), .STOP_DIR(3'b000)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop), .i_pause(i_pause),
    .i_last_address(i_last_address), .o_mem_address(o_mem_address),
    .i_mem_read_data(rdata), .o_move_dir(o_move_dir), .o_remaining(o_remaining),
    .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );

  // clock / RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rdata <= mem[o_mem_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample the cycle's settled outputs, score RUN entries, then advance.
  task automatic tick();
    #1;
    if (o_state == ST_RUN && !i_pause) begin
      run_cyc++;
      run_cnt[o_move_dir]++;
    end
    if (o_state == ST_RUN && last_state == ST_LATCH) begin
      if (exp_q.size() > 0) begin
        chk("entry_dir", 32'(o_move_dir), 32'(exp_q.pop_front()));
      end else begin
        n_checks++;
        n_err++;
        $error("FAIL entry_extra observed=dir %0d expected=no further entry", o_move_dir);
      end
    end
    last_state = o_state;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    run_cyc = 0;
    for (int d = 0; d < 8; d++) run_cnt[d] = 0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!o_done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(o_done), 32'd1);
  endtask

  task automatic wait_run_rem(input string tag, input logic [CW-1:0] rem, input int budget);
    int n;
    n = 0;
    while (!(o_state == ST_RUN && o_remaining == rem) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(o_remaining), 32'(rem));
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_pause = 1'b0; i_last_address = '0;
    clear_stats();
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_state", 32'(o_state), 32'(ST_IDLE));
    chk("rst_dir", 32'(o_move_dir), 32'd0);
    chk("rst_addr", 32'(o_mem_address), 32'd0);
    chk("rst_rem", 32'(o_remaining), 32'd0);
    chk("rst_busy_done", {30'd0, o_busy, o_done}, 32'd0);

    // Reset while running
    mem[0] = {3'd1, 14'd3};
    i_last_address = 10'd0;
    exp_q.push_back(3'd1);
    pulse_start();
    chk("start_fetch", 32'(o_state), 32'(ST_FETCH));
    wait_run_rem("t1_run", 14'd2, 40);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("t1_state", 32'(o_state), 32'(ST_IDLE));
    chk("t1_dir", 32'(o_move_dir), 32'd0);
    chk("t1_addr", 32'(o_mem_address), 32'd0);
    chk("t1_busy_done", {30'd0, o_busy, o_done}, 32'd0);

    // Two-entry route
    clear_stats();
    mem[0] = {3'd1, 14'd3};
    mem[1] = {3'd2, 14'd2};
    i_last_address = 10'd1;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    pulse_start();
    wait_done("t2_done", 100);
    chk("t2_dir1_cycles", 32'(run_cnt[1]), 32'd12);
    chk("t2_dir2_cycles", 32'(run_cnt[2]), 32'd8);
    chk("t2_dir_stop", 32'(o_move_dir), 32'd0);
    chk("t2_addr", 32'(o_mem_address), 32'd1);
    chk("t2_entries", 32'(exp_q.size()), 32'd0);

    // End marker before LastAddress; restart from DONE
    clear_stats();
    mem[0] = {3'd4, 14'd5};
    mem[1] = {3'd1, 14'd0};
    i_last_address = 10'd9;
    exp_q.push_back(3'd4);
    pulse_start();
    chk("t3_restart", 32'(o_state), 32'(ST_FETCH));
    wait_done("t3_done", 100);
    chk("t3_dir4_cycles", 32'(run_cyc), 32'd20);
    chk("t3_addr", 32'(o_mem_address), 32'd1);
    chk("t3_dir_stop", 32'(o_move_dir), 32'd0);
    chk("t3_busy", 32'(o_busy), 32'd0);

    // Pause mid-entry
    clear_stats();
    mem[0] = {3'd5, 14'd3};
    i_last_address = 10'd0;
    exp_q.push_back(3'd5);
    pulse_start();
    wait_run_rem("t4_reach_rem2", 14'd2, 40);
    i_pause = 1'b1;
    #1;
    chk("t4_pause_dir", 32'(o_move_dir), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_frozen_rem", 32'(o_remaining), 32'd2);
      chk("t4_frozen_dir", 32'(o_move_dir), 32'd0);
    end
    i_pause = 1'b0;
    #1;
    chk("t4_resume_rem", 32'(o_remaining), 32'd2);
    chk("t4_resume_dir", 32'(o_move_dir), 32'd5);
    wait_done("t4_done", 100);
    chk("t4_run_cycles", 32'(run_cyc), 32'd12);

    // Stop together with Start in DONE
    i_stop = 1'b1;
    i_start = 1'b1;
    tick();
    i_stop = 1'b0;
    i_start = 1'b0;
    chk("t5_stop_state", 32'(o_state), 32'(ST_IDLE));
    chk("t5_stop_busy", 32'(o_busy), 32'd0);
    tick();
    chk("t5_no_fetch", 32'(o_state), 32'(ST_IDLE));

    // Start pulse during RUN, then Stop mid-RUN
    clear_stats();
    mem[0] = {3'd2, 14'd4};
    exp_q.push_back(3'd2);
    pulse_start();
    wait_run_rem("t5_reach_rem3", 14'd3, 40);
    pulse_start();
    chk("t5_busy_start_addr", 32'(o_mem_address), 32'd0);
    chk("t5_busy_start_rem", 32'(o_remaining), 32'd3);
    chk("t5_busy_start_state", 32'(o_state), 32'(ST_RUN));
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("t5_stop_run_state", 32'(o_state), 32'(ST_IDLE));
    chk("t5_stop_run_rem", 32'(o_remaining), 32'd0);
    chk("t5_stop_run_dir", 32'(o_move_dir), 32'd0);

    // Full address range, no wrap
    clear_stats();
    for (int a = 0; a < 1024; a++) begin
      mem[a] = {3'd6, 14'd1};
      exp_q.push_back(3'd6);
    end
    i_last_address = 10'd1023;
    pulse_start();
    wait_done("t6_done", 8000);
    chk("t6_addr", 32'(o_mem_address), 32'd1023);
    chk("t6_run_cycles", 32'(run_cyc), 32'd4096);
    chk("t6_entries", 32'(exp_q.size()), 32'd0);
    chk("t6_dir_stop", 32'(o_move_dir), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
